renode_ahb_posted_subordinate: RTL and testbench

Synthesizable, parametrised AHB subordinate that turns AHB-Lite transfers into a valid/ready request/response backend port feeding the Renode co-simulation bridge or a local memory model. Unlike the behavioural subordinate, it pipelines address and data phases, posts writes into a WriteFifoDepth-entry buffer with zero wait states, generates byte strobes for narrow transfers, and reports late write errors through a sticky flag. It sits between the AHB interconnect and the Renode peripheral backend.

---
 rtl/renode_ahb_pkg.sv | 37 +++
 rtl/renode_sync_fifo.sv | 49 ++++
 rtl/renode_ahb_posted_subordinate.sv | 199 +++++++++++++++++++
 tb/tb_renode_ahb_posted_subordinate.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_ahb_pkg.sv
// Shared types and helpers for the posted-write AHB subordinate.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RD_DRAIN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam int unsigned MaxStrbW = 128;

    // 2^size ones shifted up to the byte lane selected by the address offset.
    function automatic logic [MaxStrbW-1:0] strb_gen(input logic [6:0] offset,
                                                     input logic [2:0] size);
        logic [MaxStrbW-1:0] ones;
        ones = (MaxStrbW'(1) << (8'd1 << size)) - MaxStrbW'(1);
        return ones << offset;
    endfunction

endpackage

// File: rtl/renode_sync_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees a slot from the next cycle.
module renode_sync_fifo
    import renode_ahb_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/renode_ahb_posted_subordinate.sv
// AHB-Lite subordinate: posted zero-wait writes, ordered reads, valid/ready backend port.
//  state     | meaning
//  IDLE      | no data phase in progress
//  WDATA     | write data phase; stalls only while the posted-write FIFO is full
//  RD_DRAIN  | read held until FIFO is empty and every write response has returned
//  RD_REQ    | read request presented to the backend
//  RD_WAIT   | read request accepted, awaiting response
//  RD_DONE   | read data returned with OKAY
//  ERR1/ERR2 | two-cycle ERROR response
module renode_ahb_posted_subordinate
    import renode_ahb_pkg::*;
#(
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned WriteFifoDepth = 4
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic                    hready,
    input  logic [AddressWidth-1:0] haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [DataWidth-1:0]    hwdata,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DataWidth-1:0]    hrdata,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [AddressWidth-1:0] req_addr,
    output logic [DataWidth/8-1:0]  req_strb,
    output logic [DataWidth-1:0]    req_wdata,
    input  logic                    rsp_valid,
    input  logic [DataWidth-1:0]    rsp_rdata,
    input  logic                    rsp_error,
    output logic                    write_error
);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned FifoW = AddressWidth + StrbW + DataWidth;
    localparam int unsigned CntW  = $clog2(WriteFifoDepth) + 1;
    localparam int unsigned PendW = $clog2(WriteFifoDepth) + 1;
    localparam logic [PendW-1:0] PendMax = PendW'(WriteFifoDepth);

    state_e                  state;
    state_e                  state_nxt;
    hresp_e                  resp;
    logic [AddressWidth-1:0] ctx_addr;
    logic [StrbW-1:0]        ctx_strb;
    logic [PendW-1:0]        pend;

    logic                    accept;
    logic                    can_accept;
    logic                    ctx_load;
    logic                    addr_invalid;
    logic [AddressWidth-1:0] size_mask;
    logic [6:0]              addr_off;
    logic [StrbW-1:0]        addr_strb;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [FifoW-1:0]        fifo_din;
    logic [FifoW-1:0]        fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CntW-1:0]         fifo_count;
    logic [AddressWidth-1:0] head_addr;
    logic [StrbW-1:0]        head_strb;
    logic [DataWidth-1:0]    head_wdata;

    logic                    rd_req;
    logic                    wr_req;
    logic                    wr_rsp;

    assign accept = hsel & hready &
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    assign size_mask    = AddressWidth'((8'd1 << hsize) - 8'd1);
    assign addr_invalid = ((9'd1 << hsize) > 9'(StrbW)) || ((haddr & size_mask) != '0);
    assign addr_off     = 7'(haddr & AddressWidth'(StrbW - 1));
    assign addr_strb    = StrbW'(strb_gen(addr_off, hsize));
    assign ctx_load     = can_accept & accept;

    assign fifo_din = {ctx_addr, ctx_strb, hwdata};
    assign {head_addr, head_strb, head_wdata} = fifo_dout;

    // Popped writes are bounded so the response counter cannot overflow.
    assign wr_req = (fifo_count != '0) && (pend != PendMax);
    assign wr_rsp = rsp_valid && (pend != '0);
    assign hresp  = resp;

    renode_sync_fifo #(
        .Width (FifoW),
        .Depth (WriteFifoDepth)
    ) u_wr_fifo (
        .clk   (hclk),
        .rst   (hreset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= ST_IDLE;
            ctx_addr    <= '0;
            ctx_strb    <= '0;
            pend        <= '0;
            write_error <= 1'b0;
            hrdata      <= '0;
        end else begin
            state <= state_nxt;
            if (ctx_load) begin
                ctx_addr <= haddr;
                ctx_strb <= addr_strb;
            end
            pend <= pend + PendW'(fifo_pop) - PendW'(wr_rsp);
            if (wr_rsp && rsp_error) write_error <= 1'b1;
            if ((state == ST_RD_WAIT) && rsp_valid) hrdata <= rsp_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        hreadyout  = 1'b1;
        resp       = HRESP_OKAY;
        can_accept = 1'b0;
        fifo_push  = 1'b0;
        rd_req     = 1'b0;
        case (state)
            ST_IDLE: can_accept = 1'b1;
            ST_WDATA: begin
                hreadyout  = ~fifo_full;
                fifo_push  = ~fifo_full;
                can_accept = ~fifo_full;
            end
            ST_RD_DRAIN: begin
                hreadyout = 1'b0;
                if (fifo_empty && (pend == '0)) state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                hreadyout = 1'b0;
                rd_req    = 1'b1;
                if (req_ready) state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                hreadyout = 1'b0;
                if (rsp_valid) state_nxt = rsp_error ? ST_ERR1 : ST_RD_DONE;
            end
            ST_RD_DONE: can_accept = 1'b1;
            ST_ERR1: begin
                hreadyout = 1'b0;
                resp      = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                resp       = HRESP_ERROR;
                can_accept = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (can_accept) begin
            if (accept) begin
                if (addr_invalid) state_nxt = ST_ERR1;
                else if (hwrite)  state_nxt = ST_WDATA;
                else              state_nxt = ST_RD_DRAIN;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_strb  = '0;
        req_wdata = '0;
        fifo_pop  = 1'b0;
        if (rd_req) begin
            req_valid = 1'b1;
            req_addr  = ctx_addr;
            req_strb  = ctx_strb;
        end else if (wr_req) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = head_addr;
            req_strb  = head_strb;
            req_wdata = head_wdata;
            fifo_pop  = req_ready;
        end
    end

endmodule

// File: tb/tb_renode_ahb_posted_subordinate.sv
// Scoreboard bench: stimulus queues expected AHB completions and backend requests.
module tb_renode_ahb_posted_subordinate;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        write_error;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    renode_ahb_posted_subordinate dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .hready      (hready),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .hreadyout   (hreadyout),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_strb    (req_strb),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .write_error (write_error)
    );

    typedef struct { logic resp; int wlo; int whi; logic chkd; logic [31:0] rdata; } ahb_exp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } req_exp_t;
    typedef struct { int due; logic err; } rsp_t;

    ahb_exp_t ahb_q[$];
    req_exp_t req_q[$];
    rsp_t     rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_delay = 1;
    logic        rsp_err_cfg = 1'b0;
    logic [31:0] rsp_rdata_cfg = 32'h0;
    bit          dphase = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backend responder: in-order responses rsp_delay cycles after each handshake.
    initial begin
        forever begin
            @(posedge hclk);
            cyc++;
            #1;
            if (hreset) begin
                rsp_q.delete();
                rsp_valid = 1'b0;
                rsp_error = 1'b0;
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_error = rsp_q[0].err;
                rsp_rdata = rsp_rdata_cfg;
                void'(rsp_q.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_error = 1'b0;
            end
        end
    end

    // AHB monitor: data-phase completion compared against the head of ahb_q.
    initial begin
        int       waits;
        logic     last_wait_err;
        ahb_exp_t e;
        waits = 0;
        last_wait_err = 1'b0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                dphase = 1'b0;
                waits  = 0;
            end else begin
                if (dphase) begin
                    if (!hreadyout) begin
                        waits++;
                        last_wait_err = hresp;
                    end else begin
                        dphase = 1'b0;
                        if (ahb_q.size() == 0) begin
                            check(1'b0, "ahb_unexpected_completion", 32'(hresp), 32'h0);
                        end else begin
                            e = ahb_q.pop_front();
                            check(hresp == e.resp, "ahb_hresp", 32'(hresp), 32'(e.resp));
                            check(waits >= e.wlo && waits <= e.whi, "ahb_wait_states",
                                  32'(waits), 32'(e.wlo));
                            if (e.resp) check(last_wait_err == 1'b1, "ahb_err_first_cycle",
                                              32'(last_wait_err), 32'h1);
                            if (e.chkd) check(hrdata == e.rdata, "ahb_hrdata", hrdata, e.rdata);
                        end
                    end
                end
                if (hsel && htrans[1] && hreadyout) begin
                    dphase = 1'b1;
                    waits  = 0;
                    last_wait_err = 1'b0;
                end
            end
        end
    end

    // Backend monitor: handshakes against req_q, stability under backpressure, read ordering.
    initial begin
        bit       stall_prev;
        logic [68:0] prev_bundle;
        req_exp_t e;
        stall_prev = 1'b0;
        prev_bundle = '0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check(req_valid && ({req_write, req_addr, req_strb, req_wdata} == prev_bundle),
                          "req_stable", req_addr, prev_bundle[67:36]);
                stall_prev  = req_valid && !req_ready;
                prev_bundle = {req_write, req_addr, req_strb, req_wdata};
                if (req_valid && req_ready) begin
                    if (req_q.size() == 0) begin
                        check(1'b0, "req_unexpected", req_addr, 32'h0);
                    end else begin
                        e = req_q.pop_front();
                        check(req_write == e.wr, "req_write", 32'(req_write), 32'(e.wr));
                        check(req_addr == e.addr, "req_addr", req_addr, e.addr);
                        check(req_strb == e.strb, "req_strb", 32'(req_strb), 32'(e.strb));
                        if (e.wr) check(req_wdata == e.wdata, "req_wdata", req_wdata, e.wdata);
                        else check(rsp_q.size() == 0 && !rsp_valid, "rd_after_wr_rsp",
                                   32'(rsp_q.size()), 32'h0);
                    end
                    rsp_q.push_back('{cyc + rsp_delay, rsp_err_cfg});
                end
            end
        end
    end

    task automatic xfer(input logic w, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d, input logic rs,
                        input int wlo, input int whi, input logic chkd, input logic [31:0] rd);
        bit   ok;
        logic r;
        ahb_q.push_back('{rs, wlo, whi, chkd, rd});
        hsel = 1'b1; htrans = tr; hwrite = w; haddr = a; hsize = sz;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge hclk);
            r = hreadyout;
            @(posedge hclk);
            if (r) ok = 1'b1;
        end
        check(ok, "addr_accept", 32'(ok), 32'h1);
        #1;
        hwdata = d; hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                      input logic [3:0] strb, input logic [1:0] tr, input int wlo, input int whi);
        req_q.push_back('{1'b1, a, strb, d});
        xfer(1'b1, tr, a, sz, d, 1'b0, wlo, whi, 1'b0, 32'h0);
    endtask

    task automatic settle();
        bit done;
        hsel = 1'b0; htrans = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge hclk);
            if (ahb_q.size() == 0 && req_q.size() == 0 && rsp_q.size() == 0 &&
                !dphase && !rsp_valid) done = 1'b1;
        end
        check(done, "settle", 32'(ahb_q.size() + req_q.size()), 32'h0);
        repeat (2) @(posedge hclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
        hsize = 3'd0; hwdata = '0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_rdata = '0; rsp_error = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        check(hreadyout == 1'b1, "rst_hreadyout", 32'(hreadyout), 32'h1);
        check(hresp == 1'b0, "rst_hresp", 32'(hresp), 32'h0);
        check(hrdata == 32'h0, "rst_hrdata", hrdata, 32'h0);
        check(req_valid == 1'b0, "rst_req_valid", 32'(req_valid), 32'h0);
        check({req_addr, req_strb, req_wdata, req_write} == '0, "rst_req_fields", req_addr, 32'h0);
        check(write_error == 1'b0, "rst_write_error", 32'(write_error), 32'h0);
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // IDLE and BUSY with hsel: OKAY, no wait, no backend traffic
        hsel = 1'b1; htrans = 2'b00;
        @(negedge hclk);
        check(hreadyout && !hresp, "idle_okay", {30'h0, hreadyout, hresp}, 32'h2);
        @(posedge hclk); #1; htrans = 2'b01;
        @(negedge hclk);
        check(hreadyout && !hresp, "busy_okay", {30'h0, hreadyout, hresp}, 32'h2);
        @(posedge hclk); #1;

        // Single word, byte and halfword writes; invalid transfers
        wr(32'h0000_1000, 3'd2, 32'hDEAD_BEEF, 4'hF, 2'b10, 0, 0);
        wr(32'h0000_1003, 3'd0, 32'hAB00_0000, 4'b1000, 2'b10, 0, 0);
        wr(32'h0000_1002, 3'd1, 32'h5A5A_0000, 4'b1100, 2'b10, 0, 0);
        xfer(1'b1, 2'b10, 32'h0000_1002, 3'd2, 32'h1111_1111, 1'b1, 1, 1, 1'b0, 32'h0);
        xfer(1'b0, 2'b10, 32'h0000_1000, 3'd3, 32'h0, 1'b1, 1, 1, 1'b0, 32'h0);
        wr(32'h0000_1001, 3'd0, 32'h0000_C300, 4'b0010, 2'b10, 0, 0);
        settle();
        check(write_error == 1'b0, "no_write_error", 32'(write_error), 32'h0);

        // Six back-to-back writes against a stalled backend
        req_ready = 1'b0;
        fork
            begin
                wr(32'h0000_0100, 3'd2, 32'hA0A0_0001, 4'hF, 2'b10, 0, 0);
                wr(32'h0000_0104, 3'd2, 32'hA0A0_0002, 4'hF, 2'b11, 0, 0);
                wr(32'h0000_0108, 3'd2, 32'hA0A0_0003, 4'hF, 2'b11, 0, 0);
                wr(32'h0000_010C, 3'd2, 32'hA0A0_0004, 4'hF, 2'b11, 0, 0);
                wr(32'h0000_0110, 3'd2, 32'hA0A0_0005, 4'hF, 2'b11, 4, 8);
                wr(32'h0000_0114, 3'd2, 32'hA0A0_0006, 4'hF, 2'b11, 0, 0);
            end
            begin
                repeat (10) @(posedge hclk);
                #1;
                req_ready = 1'b1;
            end
        join
        settle();

        // Write then read with a slow backend: read waits for the write response
        rsp_delay = 3;
        rsp_rdata_cfg = 32'hCAFE_F00D;
        wr(32'h0000_2000, 3'd2, 32'h1122_3344, 4'hF, 2'b10, 0, 0);
        req_q.push_back('{1'b0, 32'h0000_2000, 4'hF, 32'h0});
        xfer(1'b0, 2'b10, 32'h0000_2000, 3'd2, 32'h0, 1'b0, 3, 40, 1'b1, 32'hCAFE_F00D);
        settle();

        // Backend errors: posted write sets sticky flag, read becomes ERROR
        rsp_delay = 1;
        rsp_err_cfg = 1'b1;
        wr(32'h0000_3000, 3'd2, 32'h0BAD_0BAD, 4'hF, 2'b10, 0, 0);
        settle();
        check(write_error == 1'b1, "write_error_set", 32'(write_error), 32'h1);
        req_q.push_back('{1'b0, 32'h0000_3004, 4'hF, 32'h0});
        xfer(1'b0, 2'b10, 32'h0000_3004, 3'd2, 32'h0, 1'b1, 4, 40, 1'b0, 32'h0);
        settle();
        rsp_err_cfg = 1'b0;
        wr(32'h0000_3008, 3'd2, 32'h7777_8888, 4'hF, 2'b10, 0, 0);
        settle();
        check(write_error == 1'b1, "write_error_sticky", 32'(write_error), 32'h1);

        // Reset in the middle of a read
        rsp_delay = 20;
        req_q.push_back('{1'b0, 32'h0000_4000, 4'hF, 32'h0});
        xfer(1'b0, 2'b10, 32'h0000_4000, 3'd2, 32'h0, 1'b0, 3, 40, 1'b1, 32'hCAFE_F00D);
        repeat (8) @(posedge hclk);
        #1;
        hreset = 1'b1;
        ahb_q.delete(); req_q.delete(); rsp_q.delete();
        @(posedge hclk);
        #1;
        check(hreadyout == 1'b1, "midrst_hreadyout", 32'(hreadyout), 32'h1);
        check(hresp == 1'b0, "midrst_hresp", 32'(hresp), 32'h0);
        check(req_valid == 1'b0, "midrst_req_valid", 32'(req_valid), 32'h0);
        check(write_error == 1'b0, "midrst_write_error", 32'(write_error), 32'h0);
        check(hrdata == 32'h0, "midrst_hrdata", hrdata, 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        rsp_delay = 1;
        wr(32'h0000_5000, 3'd2, 32'h0123_4567, 4'hF, 2'b10, 0, 0);
        settle();
        check(write_error == 1'b0, "post_rst_write_error", 32'(write_error), 32'h0);
        check(ahb_q.size() == 0 && req_q.size() == 0, "queues_drained",
              32'(ahb_q.size() + req_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
